// File: rtl/shift_data_driver_if.sv
// Upstream word handshake for the 74HC595 serial data driver.
interface shift_data_driver_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/shift_data_driver.sv
// Serialises parallel words onto a 74HC595 chain, following shift/latch strobes
// from an external clock generator, with short-frame and watchdog abort.
module shift_data_driver #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                  CLOCK_16,
  input  logic                  RESET,
  shift_data_driver_if.slave    up,
  input  logic                  SHIFT_CLK_IN,
  input  logic                  LATCH_CLK_IN,
  output logic                  frame_start,
  output logic                  DATA_OUT,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH_WAIT} state_t;

  state_t             state;
  logic [WIDTH-1:0]   shift_reg;
  logic [WIDTH-1:0]   pending_word;
  logic               pending_valid;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WD_W-1:0]    watchdog;
  logic               shift_prev;
  logic               latch_prev;

  logic shift_rise, shift_fall, latch_rise, latch_fall, any_edge;

  assign shift_rise = SHIFT_CLK_IN & ~shift_prev;
  assign shift_fall = ~SHIFT_CLK_IN & shift_prev;
  assign latch_rise = LATCH_CLK_IN & ~latch_prev;
  assign latch_fall = ~LATCH_CLK_IN & latch_prev;
  assign any_edge   = shift_rise | shift_fall | latch_rise | latch_fall;

  // Outputs decoded straight from registers, so they stay glitch-free.
  assign up.word_ready = ~pending_valid;
  assign DATA_OUT      = shift_reg[WIDTH-1];
  assign busy          = (state != IDLE);

  // Frame sequencer: pending buffer, strobe tracking, shifting and abort paths.
  always_ff @(posedge CLOCK_16) begin
    if (RESET) begin
      state         <= IDLE;
      shift_reg     <= {WIDTH{1'b0}};
      pending_word  <= {WIDTH{1'b0}};
      pending_valid <= 1'b0;
      bit_cnt       <= {CNT_W{1'b0}};
      watchdog      <= {WD_W{1'b0}};
      shift_prev    <= 1'b0;
      latch_prev    <= 1'b0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      shift_prev  <= SHIFT_CLK_IN;
      latch_prev  <= LATCH_CLK_IN;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;

      if (up.word_valid && !pending_valid) begin
        pending_word  <= up.word_in;
        pending_valid <= 1'b1;
      end else begin
        pending_word  <= pending_word;
      end

      case (state)
        IDLE: begin
          if (pending_valid) begin
            shift_reg     <= pending_word;
            pending_valid <= 1'b0;
            bit_cnt       <= {CNT_W{1'b0}};
            watchdog      <= {WD_W{1'b0}};
            frame_start   <= 1'b1;
            state         <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end

        SHIFT: begin
          // A latch rise here means the generator ended the frame early; it
          // wins over a coincident shift rise so bit_cnt is left untouched.
          if (latch_rise) begin
            frame_err <= 1'b1;
            shift_reg <= {WIDTH{1'b0}};
            state     <= IDLE;
          end else if (shift_rise) begin
            watchdog <= {WD_W{1'b0}};
            if (bit_cnt != CNT_MAX) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end else begin
              bit_cnt <= bit_cnt;
            end
            if (bit_cnt == CNT_LAST) begin
              state <= LATCH_WAIT;
            end else begin
              state <= SHIFT;
            end
          end else if (shift_fall) begin
            watchdog <= {WD_W{1'b0}};
            if (bit_cnt < CNT_MAX) begin
              shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            end else begin
              shift_reg <= shift_reg;
            end
          end else if (latch_fall) begin
            watchdog <= {WD_W{1'b0}};
          end else if (watchdog == WD_LAST) begin
            frame_err <= 1'b1;
            shift_reg <= {WIDTH{1'b0}};
            state     <= IDLE;
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end

        LATCH_WAIT: begin
          if (latch_rise) begin
            frame_done <= 1'b1;
            shift_reg  <= {WIDTH{1'b0}};
            state      <= IDLE;
          end else if (any_edge) begin
            watchdog <= {WD_W{1'b0}};
          end else if (watchdog == WD_LAST) begin
            frame_err <= 1'b1;
            shift_reg <= {WIDTH{1'b0}};
            state     <= IDLE;
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end

        default: begin
          shift_reg <= {WIDTH{1'b0}};
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_data_driver.sv
// Directed bench for shift_data_driver: single, back-to-back, short, timeout,
// simultaneous-strobe and mid-frame reset cases.
module tb_shift_data_driver;

  logic CLOCK_16;
  logic RESET;
  logic SHIFT_CLK_IN;
  logic LATCH_CLK_IN;
  logic frame_start;
  logic DATA_OUT;
  logic busy;
  logic frame_done;
  logic frame_err;

  int tests_run = 0;
  int tests_failed = 0;

  shift_data_driver_if #(.WIDTH(16)) bus ();

  shift_data_driver #(.WIDTH(16), .TIMEOUT(32)) dut (
    .CLOCK_16     (CLOCK_16),
    .RESET        (RESET),
    .up           (bus),
    .SHIFT_CLK_IN (SHIFT_CLK_IN),
    .LATCH_CLK_IN (LATCH_CLK_IN),
    .frame_start  (frame_start),
    .DATA_OUT     (DATA_OUT),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_err    (frame_err)
  );

  initial CLOCK_16 = 1'b0;
  always #5 CLOCK_16 = ~CLOCK_16;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_16);
    #1;
  endtask

  task automatic shift_pulses(input int n, output logic [15:0] bits);
    bits = 16'h0000;
    for (int i = 0; i < n; i++) begin
      bits = {bits[14:0], DATA_OUT};
      SHIFT_CLK_IN = 1'b1;
      tick();
      SHIFT_CLK_IN = 1'b0;
      tick();
    end
  endtask

  task automatic load_word(input logic [15:0] w);
    bus.word_in    = w;
    bus.word_valid = 1'b1;
    tick();
    bus.word_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit: got timeout expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [15:0] bits;
    int k;
    RESET = 1'b1;
    SHIFT_CLK_IN = 1'b0;
    LATCH_CLK_IN = 1'b0;
    bus.word_in = 16'h0000;
    bus.word_valid = 1'b0;
    tick();
    tick();
    check_value("rst_ready", 32'(bus.word_ready), 32'd1);
    check_value("rst_data", 32'(DATA_OUT), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_pulses", 32'({frame_start, frame_done, frame_err}), 32'd0);
    RESET = 1'b0;
    tick();

    // Single frame 0xA5C3
    bus.word_in = 16'hA5C3;
    bus.word_valid = 1'b1;
    tick();
    bus.word_valid = 1'b0;
    check_value("acc_ready", 32'(bus.word_ready), 32'd0);
    check_value("acc_busy", 32'(busy), 32'd0);
    check_value("acc_start", 32'(frame_start), 32'd0);
    tick();
    check_value("load_start", 32'(frame_start), 32'd1);
    check_value("load_busy", 32'(busy), 32'd1);
    check_value("load_data", 32'(DATA_OUT), 32'd1);
    check_value("load_ready", 32'(bus.word_ready), 32'd1);
    shift_pulses(16, bits);
    check_value("single_bits", 32'(bits), 32'hA5C3);
    check_value("lw_busy", 32'(busy), 32'd1);
    check_value("lw_hold_last", 32'(DATA_OUT), 32'd1);
    LATCH_CLK_IN = 1'b1;
    tick();
    check_value("single_done", 32'(frame_done), 32'd1);
    check_value("single_noerr", 32'(frame_err), 32'd0);
    check_value("single_data0", 32'(DATA_OUT), 32'd0);
    check_value("single_idle", 32'(busy), 32'd0);
    LATCH_CLK_IN = 1'b0;
    tick();
    check_value("single_done_pulse", 32'(frame_done), 32'd0);

    // Back-to-back: 0xA5C3 then 0x0F0F
    bus.word_in = 16'hA5C3;
    bus.word_valid = 1'b1;
    tick();
    bus.word_in = 16'h0F0F;
    check_value("b2b_ready_pre", 32'(bus.word_ready), 32'd0);
    tick();
    check_value("b2b_start1", 32'(frame_start), 32'd1);
    check_value("b2b_ready_load", 32'(bus.word_ready), 32'd1);
    tick();
    bus.word_valid = 1'b0;
    check_value("b2b_ready_full", 32'(bus.word_ready), 32'd0);
    shift_pulses(16, bits);
    check_value("b2b_bits1", 32'(bits), 32'hA5C3);
    LATCH_CLK_IN = 1'b1;
    tick();
    check_value("b2b_done1", 32'(frame_done), 32'd1);
    check_value("b2b_nostart", 32'(frame_start), 32'd0);
    LATCH_CLK_IN = 1'b0;
    tick();
    check_value("b2b_start2", 32'(frame_start), 32'd1);
    check_value("b2b_data2", 32'(DATA_OUT), 32'd0);
    check_value("b2b_busy2", 32'(busy), 32'd1);
    shift_pulses(16, bits);
    check_value("b2b_bits2", 32'(bits), 32'h0F0F);
    LATCH_CLK_IN = 1'b1;
    tick();
    check_value("b2b_done2", 32'(frame_done), 32'd1);
    LATCH_CLK_IN = 1'b0;
    tick();

    // Short frame with a pending word kept across the abort
    load_word(16'hFFFF);
    shift_pulses(9, bits);
    bus.word_in = 16'h9234;
    bus.word_valid = 1'b1;
    tick();
    bus.word_valid = 1'b0;
    LATCH_CLK_IN = 1'b1;
    tick();
    check_value("short_err", 32'(frame_err), 32'd1);
    check_value("short_nodone", 32'(frame_done), 32'd0);
    check_value("short_data", 32'(DATA_OUT), 32'd0);
    check_value("short_idle", 32'(busy), 32'd0);
    LATCH_CLK_IN = 1'b0;
    tick();
    check_value("short_pending_start", 32'(frame_start), 32'd1);
    check_value("short_pending_data", 32'(DATA_OUT), 32'd1);
    check_value("short_err_pulse", 32'(frame_err), 32'd0);

    // Simultaneous shift and latch rise
    shift_pulses(2, bits);
    SHIFT_CLK_IN = 1'b1;
    LATCH_CLK_IN = 1'b1;
    tick();
    check_value("sim_err", 32'(frame_err), 32'd1);
    check_value("sim_nodone", 32'(frame_done), 32'd0);
    check_value("sim_bitcnt", 32'(dut.bit_cnt), 32'd2);
    check_value("sim_idle", 32'(busy), 32'd0);
    SHIFT_CLK_IN = 1'b0;
    LATCH_CLK_IN = 1'b0;
    tick();

    // Strobes while idle are ignored
    shift_pulses(2, bits);
    LATCH_CLK_IN = 1'b1;
    tick();
    check_value("idle_strobe_done", 32'(frame_done), 32'd0);
    check_value("idle_strobe_err", 32'(frame_err), 32'd0);
    LATCH_CLK_IN = 1'b0;
    tick();
    check_value("idle_strobe_busy", 32'(busy), 32'd0);

    // Watchdog: strobes stop after 3 bits
    load_word(16'hFFFF);
    shift_pulses(3, bits);
    k = 0;
    while (!frame_err && k < 100) begin
      tick();
      k++;
    end
    check_value("timeout_cycles", 32'(k), 32'd32);
    check_value("timeout_idle", 32'(busy), 32'd0);
    check_value("timeout_data", 32'(DATA_OUT), 32'd0);
    tick();

    // Reset mid-frame
    load_word(16'hFFFF);
    shift_pulses(5, bits);
    bus.word_in = 16'h1234;
    bus.word_valid = 1'b1;
    tick();
    bus.word_valid = 1'b0;
    check_value("mid_pre_data", 32'(DATA_OUT), 32'd1);
    check_value("mid_pre_ready", 32'(bus.word_ready), 32'd0);
    RESET = 1'b1;
    tick();
    check_value("mid_rst_data", 32'(DATA_OUT), 32'd0);
    check_value("mid_rst_busy", 32'(busy), 32'd0);
    check_value("mid_rst_ready", 32'(bus.word_ready), 32'd1);
    check_value("mid_rst_pulses", 32'({frame_start, frame_done, frame_err}), 32'd0);
    RESET = 1'b0;
    tick();
    tick();
    check_value("mid_post_busy", 32'(busy), 32'd0);
    check_value("mid_post_pulses", 32'({frame_start, frame_done, frame_err}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
